// File: rtl/ldstr_mem_scheduler_if.sv
// Handshake/bus bundle between dispatch, the load/store buffer, dmem and the
// ldstr_mem_scheduler; the scheduler uses the slave modport.
interface ldstr_mem_scheduler_if #(
   parameter int N     = 8,
   parameter int IDX_W = 3
);
   logic             flush;
   logic             alloc;
   logic             alloc_is_store;
   logic [IDX_W-1:0] alloc_idx;
   logic             full;
   logic [N-1:0]     ready_vec;
   logic             store_commit;
   logic [IDX_W-1:0] sel_idx;
   logic             mem_go;
   logic             dmem_resp;
   logic             cdb_valid;
   logic             slot_release;
   logic [IDX_W:0]   count;

   modport master (
      output flush, alloc, alloc_is_store, ready_vec, store_commit, dmem_resp,
      input  alloc_idx, full, sel_idx, mem_go, cdb_valid, slot_release, count
   );

   modport slave (
      input  flush, alloc, alloc_is_store, ready_vec, store_commit, dmem_resp,
      output alloc_idx, full, sel_idx, mem_go, cdb_valid, slot_release, count
   );
endinterface

// File: rtl/ldstr_mem_scheduler.sv
// In-order issue/complete sequencer for the 8-entry load/store reservation buffer.
// Optional macro LDSTR_STORE_COMMIT_EN holds a head store until the ROB commits it.
module ldstr_mem_scheduler #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   ldstr_mem_scheduler_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;
   localparam logic [1:0] DRAIN  = 2'd3;

   logic [1:0]       state_r;
   logic [1:0]       state_next_s;
   logic [IDX_W-1:0] head_r;
   logic [IDX_W-1:0] tail_r;
   logic [IDX_W:0]   count_r;
   logic [N-1:0]     is_store_r;
   logic             full_s;
   logic             accept_s;
   logic             release_s;
   logic             store_ok_s;
   logic             issue_s;

`ifdef LDSTR_STORE_COMMIT_EN
   assign store_ok_s = !is_store_r[head_r] | bus.store_commit;
`else
   assign store_ok_s = 1'b1;
`endif

   assign full_s    = (count_r == (IDX_W+1)'(N)) | (state_r == DRAIN);
   assign accept_s  = bus.alloc & !full_s & !bus.flush;
   assign release_s = (state_r == DONE) & !bus.flush;
   // Only the head slot is considered, so memory order always equals program order.
   assign issue_s   = (count_r != {(IDX_W+1){1'b0}}) & bus.ready_vec[head_r] & store_ok_s;

   // Next-state logic; a flush during an access must still wait out the memory reply.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!bus.flush && issue_s) begin
               state_next_s = ACCESS;
            end else begin
               state_next_s = IDLE;
            end
         end
         ACCESS: begin
            if (bus.flush) begin
               state_next_s = DRAIN;
            end else if (bus.dmem_resp) begin
               state_next_s = DONE;
            end else begin
               state_next_s = ACCESS;
            end
         end
         DONE: begin
            state_next_s = IDLE;
         end
         DRAIN: begin
            if (bus.dmem_resp && !bus.flush) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DRAIN;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Circular age queue: pointers, occupancy and per-slot store flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_r     <= {IDX_W{1'b0}};
         tail_r     <= {IDX_W{1'b0}};
         count_r    <= {(IDX_W+1){1'b0}};
         is_store_r <= {N{1'b0}};
      end else if (bus.flush) begin
         head_r     <= {IDX_W{1'b0}};
         tail_r     <= {IDX_W{1'b0}};
         count_r    <= {(IDX_W+1){1'b0}};
         is_store_r <= {N{1'b0}};
      end else begin
         if (accept_s) begin
            is_store_r[tail_r] <= bus.alloc_is_store;
            tail_r             <= tail_r + IDX_W'(1);
         end
         if (release_s) begin
            head_r <= head_r + IDX_W'(1);
         end
         if (accept_s && !release_s) begin
            count_r <= count_r + (IDX_W+1)'(1);
         end else if (!accept_s && release_s) begin
            count_r <= count_r - (IDX_W+1)'(1);
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Output decode from the state registers; completion strobes are masked by flush.
   always_comb begin
      bus.mem_go       = 1'b0;
      bus.cdb_valid    = 1'b0;
      bus.slot_release = 1'b0;
      case (state_r)
         ACCESS, DRAIN: begin
            bus.mem_go = 1'b1;
         end
         DONE: begin
            bus.slot_release = release_s;
            bus.cdb_valid    = release_s & !is_store_r[head_r];
         end
         default: begin
            bus.mem_go = 1'b0;
         end
      endcase
   end

   assign bus.full      = full_s;
   assign bus.alloc_idx = tail_r;
   assign bus.sel_idx   = head_r;
   assign bus.count     = count_r;
endmodule

// File: tb/tb_ldstr_mem_scheduler.sv
// Directed self-checking bench for ldstr_mem_scheduler (default or LDSTR_STORE_COMMIT_EN build).
module tb_ldstr_mem_scheduler;
   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   ldstr_mem_scheduler_if #(.N(8), .IDX_W(3)) bus ();

   ldstr_mem_scheduler #(.N(8), .IDX_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.flush          = 1'b0;
      bus.alloc          = 1'b0;
      bus.alloc_is_store = 1'b0;
      bus.ready_vec      = 8'h00;
      bus.store_commit   = 1'b0;
      bus.dmem_resp      = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      tests_run++;
      if ({bus.full, bus.mem_go, bus.cdb_valid, bus.slot_release} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags got full/mem_go/cdb/rel=%b exp=0000",
                  {bus.full, bus.mem_go, bus.cdb_valid, bus.slot_release});
      end
      tests_run++;
      if ({bus.sel_idx, bus.alloc_idx} !== 6'd0) begin
         tests_failed++;
         $display("FAIL reset_idx got sel=%0d alloc=%0d exp=0/0", bus.sel_idx, bus.alloc_idx);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_three_loads();
      int n_pulse;
      int pulse_cyc[3];
      logic [2:0] pulse_sel[3];
      do_reset();
      bus.ready_vec = 8'hFF;
      bus.dmem_resp = 1'b1;
      n_pulse = 0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         bus.alloc = (cyc < 3);
         @(negedge clk);
         if (bus.cdb_valid === 1'b1) begin
            if (n_pulse < 3) begin
               pulse_cyc[n_pulse] = cyc;
               pulse_sel[n_pulse] = bus.sel_idx;
            end
            n_pulse++;
         end
      end
      bus.alloc = 1'b0;
      tests_run++;
      if (n_pulse != 3) begin tests_failed++; $display("FAIL loads_pulses got=%0d exp=3", n_pulse); end
      if (n_pulse == 3) begin
         tests_run++;
         if (pulse_cyc[0] != 2) begin tests_failed++; $display("FAIL loads_first_cycle got=%0d exp=2", pulse_cyc[0]); end
         tests_run++;
         if (pulse_cyc[1] - pulse_cyc[0] != 3 || pulse_cyc[2] - pulse_cyc[1] != 3) begin
            tests_failed++;
            $display("FAIL loads_spacing got=%0d,%0d exp=3,3", pulse_cyc[1] - pulse_cyc[0], pulse_cyc[2] - pulse_cyc[1]);
         end
         tests_run++;
         if (pulse_sel[0] !== 3'd0 || pulse_sel[1] !== 3'd1 || pulse_sel[2] !== 3'd2) begin
            tests_failed++;
            $display("FAIL loads_sel got=%0d,%0d,%0d exp=0,1,2", pulse_sel[0], pulse_sel[1], pulse_sel[2]);
         end
      end
      tests_run++;
      if (bus.count !== 4'd0) begin tests_failed++; $display("FAIL loads_count_end got=%0d exp=0", bus.count); end
   endtask

   task automatic test_full_wrap();
      bit seen;
      do_reset();
      bus.alloc = 1'b1;
      for (int i = 0; i < 8; i++) @(negedge clk);
      tests_run++;
      if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
         tests_failed++;
         $display("FAIL full_after8 got full=%b count=%0d exp=1/8", bus.full, bus.count);
      end
      @(negedge clk);
      bus.alloc = 1'b0;
      tests_run++;
      if (bus.count !== 4'd8 || bus.alloc_idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL full_ninth_ignored got count=%0d tail=%0d exp=8/0", bus.count, bus.alloc_idx);
      end
      bus.ready_vec = 8'h01;
      bus.dmem_resp = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.slot_release === 1'b1) seen = 1'b1;
      end
      tests_run++;
      if (!seen) begin tests_failed++; $display("FAIL full_release got=none exp=slot_release pulse"); end
      @(negedge clk);
      tests_run++;
      if (bus.full !== 1'b0 || bus.count !== 4'd7 || bus.alloc_idx !== 3'd0 || bus.sel_idx !== 3'd1) begin
         tests_failed++;
         $display("FAIL full_drop got full=%b count=%0d tail=%0d head=%0d exp=0/7/0/1",
                  bus.full, bus.count, bus.alloc_idx, bus.sel_idx);
      end
      bus.alloc = 1'b1;
      @(negedge clk);
      bus.alloc = 1'b0;
      tests_run++;
      if (bus.count !== 4'd8 || bus.alloc_idx !== 3'd1 || bus.full !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_alloc got count=%0d tail=%0d full=%b exp=8/1/1", bus.count, bus.alloc_idx, bus.full);
      end
   endtask

   task automatic test_no_bypass();
      int go_cnt;
      bit seen;
      do_reset();
      bus.ready_vec = 8'h02;
      bus.alloc     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.alloc = 1'b0;
      go_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.mem_go === 1'b1) go_cnt++;
      end
      tests_run++;
      if (go_cnt != 0) begin tests_failed++; $display("FAIL no_bypass got mem_go cycles=%0d exp=0", go_cnt); end
      bus.ready_vec = 8'h03;
      bus.dmem_resp = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.cdb_valid === 1'b1) begin
            seen = 1'b1;
            tests_run++;
            if (bus.sel_idx !== 3'd0) begin
               tests_failed++;
               $display("FAIL in_order_first got sel=%0d exp=0", bus.sel_idx);
            end
         end
      end
      tests_run++;
      if (!seen) begin tests_failed++; $display("FAIL in_order_cdb got=none exp=pulse"); end
   endtask

   task automatic test_store();
      bit seen;
      int rel_cyc;
      do_reset();
      bus.ready_vec      = 8'hFF;
      bus.dmem_resp      = 1'b1;
      bus.alloc          = 1'b1;
      bus.alloc_is_store = 1'b1;
      @(negedge clk);
      bus.alloc          = 1'b0;
      bus.alloc_is_store = 1'b0;
`ifdef LDSTR_STORE_COMMIT_EN
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++;
         if (bus.mem_go !== 1'b0) begin tests_failed++; $display("FAIL store_wait_commit cyc=%0d got mem_go=%b exp=0", i, bus.mem_go); end
      end
      bus.store_commit = 1'b1;
`endif
      seen    = 1'b0;
      rel_cyc = -1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.slot_release === 1'b1) begin
            seen    = 1'b1;
            rel_cyc = i;
            tests_run++;
            if (bus.cdb_valid !== 1'b0) begin tests_failed++; $display("FAIL store_cdb got=%b exp=0", bus.cdb_valid); end
         end
      end
      bus.store_commit = 1'b0;
      tests_run++;
      if (rel_cyc != 1) begin tests_failed++; $display("FAIL store_release_cycle got=%0d exp=1", rel_cyc); end
   endtask

   task automatic test_flush_drain();
      bit seen;
      int cdb_cnt;
      do_reset();
      bus.ready_vec = 8'hFF;
      bus.alloc     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.alloc = 1'b0;
      seen = (bus.mem_go === 1'b1);
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.mem_go === 1'b1) seen = 1'b1;
      end
      tests_run++;
      if (!seen) begin tests_failed++; $display("FAIL flush_access got=no mem_go exp=mem_go"); end
      cdb_cnt   = 0;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.alloc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (bus.mem_go !== 1'b1 || bus.full !== 1'b1 || bus.count !== 4'd0) begin
            tests_failed++;
            $display("FAIL drain_hold cyc=%0d got mem_go=%b full=%b count=%0d exp=1/1/0", i, bus.mem_go, bus.full, bus.count);
         end
         if (bus.cdb_valid === 1'b1 || bus.slot_release === 1'b1) cdb_cnt++;
         @(negedge clk);
      end
      bus.alloc     = 1'b0;
      bus.dmem_resp = 1'b1;
      @(negedge clk);
      bus.dmem_resp = 1'b0;
      if (bus.cdb_valid === 1'b1 || bus.slot_release === 1'b1) cdb_cnt++;
      tests_run++;
      if (bus.mem_go !== 1'b0 || bus.full !== 1'b0 || bus.count !== 4'd0) begin
         tests_failed++;
         $display("FAIL drain_exit got mem_go=%b full=%b count=%0d exp=0/0/0", bus.mem_go, bus.full, bus.count);
      end
      tests_run++;
      if (cdb_cnt != 0) begin tests_failed++; $display("FAIL drain_no_strobe got=%0d exp=0", cdb_cnt); end
   endtask

   task automatic test_back_to_back();
      bit seen;
      do_reset();
      bus.dmem_resp = 1'b1;
      bus.alloc     = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);
      bus.alloc     = 1'b0;
      bus.ready_vec = 8'h01;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.mem_go === 1'b1) seen = 1'b1;
      end
      @(negedge clk);
      tests_run++;
      if (bus.slot_release !== 1'b1 || bus.count !== 4'd4) begin
         tests_failed++;
         $display("FAIL b2b_done got release=%b count=%0d exp=1/4", bus.slot_release, bus.count);
      end
      bus.alloc = 1'b1;
      @(negedge clk);
      bus.alloc = 1'b0;
      tests_run++;
      if (bus.count !== 4'd4 || bus.sel_idx !== 3'd1 || bus.alloc_idx !== 3'd5) begin
         tests_failed++;
         $display("FAIL b2b_count got count=%0d head=%0d tail=%0d exp=4/1/5", bus.count, bus.sel_idx, bus.alloc_idx);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      test_reset();
      test_three_loads();
      test_full_wrap();
      test_no_bypass();
      test_store();
      test_flush_drain();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/ldstr_mem_scheduler.md
Name: ldstr_mem_scheduler

Overview:
- Sequencing controller for the 8-entry load/store reservation buffer.
- Allocates buffer slots in program order and keeps a circular age queue.
- Picks the oldest slot whose operands are valid, drives the buffer read-select and the dmem handshake, and frees the slot after completion.
- Pulses a CDB-valid strobe when a load completes.

Parameters:
- N, 8, number of buffer slots; must be a power of 2.
- IDX_W, 3, slot index width; equals log2(N).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch mispredict).
- alloc  in  1  dispatch writes a new load/store into slot alloc_idx this cycle.
- alloc_is_store  in  1  1 = the allocated op is a store (STR/STB); 0 = load.
- alloc_idx  out  IDX_W  slot to write (the tail pointer); drives the buffer's issue decode.
- full  out  1  no slot is free, or a drain is in progress; dispatch must not alloc.
- ready_vec  in  N  per-slot operands valid (Vbase_valid & Vsrc_valid, from the buffer).
- store_commit  in  1  ROB: the store at the head is non-speculative (see Optional Feature).
- sel_idx  out  IDX_W  buffer read-select (r_addr_out); equals head.
- mem_go  out  1  enables the selected slot's dmem_read/dmem_write onto the memory port.
- dmem_resp  in  1  memory response for the current access.
- cdb_valid  out  1  one-cycle pulse: the selected load result is valid on CDB_out.
- slot_release  out  1  one-cycle pulse: free slot sel_idx (ld_buffer_read).
- count  out  IDX_W+1  number of occupied slots.

Behaviour:
- State held: head, tail (IDX_W each, wrap modulo N), count, is_store[N], and FSM states IDLE, ACCESS, DONE, DRAIN.
- Reset (async, active-high) sets:
  - head = tail = count = 0, is_store = 0, state = IDLE;
  - all outputs 0 except sel_idx = 0, alloc_idx = 0.
- full = (count == N) | (state == DRAIN).
- alloc_idx = tail; sel_idx = head.
- Allocation: when alloc & !full & !flush,
  - is_store[tail] <= alloc_is_store and tail <= tail + 1.
- Alloc while full is ignored: no pointer or count change.
- Release: in DONE, head <= head + 1.
- count update: +1 on accepted alloc, -1 on release; simultaneous alloc and release leaves count unchanged.
- IDLE:
  - Go to ACCESS when count != 0 & ready_vec[head] & store_ok.
  - store_ok = !is_store[head] | store_commit when LDSTR_STORE_COMMIT_EN is defined; otherwise store_ok = 1.
  - mem_go = 0 in IDLE.
  - Only the head slot is ever examined; a younger ready slot never bypasses it (strict in-order memory).
- ACCESS:
  - mem_go = 1 and sel_idx held stable.
  - Stay in ACCESS until dmem_resp, then go to DONE.
  - Latency: a zero-wait memory gives IDLE -> ACCESS -> DONE -> IDLE, i.e. 3 cycles per op.
- DONE (one cycle):
  - mem_go = 0 and slot_release = 1.
  - cdb_valid = !is_store[head].
  - Next state is IDLE.
- Flush (synchronous; takes priority over alloc and release):
  - head = tail = count = 0 and is_store cleared.
  - From IDLE or DONE: go to IDLE; slot_release and cdb_valid are suppressed that cycle.
  - From ACCESS: go to DRAIN. mem_go stays 1 until dmem_resp so the in-flight memory transaction completes, then IDLE. No cdb_valid or slot_release occurs.
  - full = 1 during DRAIN; alloc is ignored.
- Flush during DRAIN: stay in DRAIN.
- dmem_resp in IDLE or DONE is ignored.
- Wrap-around: pointers roll from N-1 to 0; head == tail is disambiguated by count.

Optional Feature:
- Macro: LDSTR_STORE_COMMIT_EN.
- Defined: a store at the head does not leave IDLE until store_commit = 1. Stores never write memory speculatively.
- Undefined: store_commit is unused. A store issues as soon as its operands are ready, and flush cannot undo a store that has already written memory.

Test Plan:
- Reset, then alloc 3 loads with ready_vec = 8'hFF and 1-cycle resp -> sel_idx goes 0, 1, 2; cdb_valid pulses three times, 3 cycles apart; count ends at 0.
- Alloc 8 ops with ready_vec = 0 -> full = 1 and count = 8; a 9th alloc is ignored (tail = 0, count = 8). Set ready_vec[0] = 1 -> slot 0 completes, full drops, and the next alloc writes slot 0 (wrap).
- Load in slot 0 not ready, load in slot 1 ready -> mem_go stays 0 (no bypass). Set ready_vec[0] = 1 -> slot 0 is serviced first.
- With LDSTR_STORE_COMMIT_EN: ready store at head, store_commit = 0 for 5 cycles -> mem_go = 0. Assert store_commit -> ACCESS, then DONE with slot_release = 1 and cdb_valid = 0.
- Flush while in ACCESS with resp delayed 4 cycles -> DRAIN, full = 1, mem_go held 1 until resp; then IDLE with count = 0 and no cdb_valid.
- Alloc and DONE in the same cycle with count = 4 -> count stays 4, head +1, tail +1.
